// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin resource arbiter.
// The master side drives enable/requests, the slave (arbiter) drives grant outputs.
interface rr_resource_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_vld;
    logic [ID_W-1:0]    gnt_id;
    logic               preempt;

    modport master (output en, req, input gnt, gnt_vld, gnt_id, preempt);
    modport slave  (input en, req, output gnt, gnt_vld, gnt_id, preempt);
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin owner arbiter for one shared resource with MAX_HOLD preemption.
// gnt_id feeds the resource mux select directly; every handover passes through IDLE.
module rr_resource_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst,
    rr_resource_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   N_EXT     = (ID_W+1)'(NUM_REQ);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]         r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [HC_W-1:0]    r_hold_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_gnt_vld;
    logic [ID_W-1:0]    r_gnt_id;
    logic               r_preempt;

    logic [ID_W-1:0]    w_sel;
    logic               w_sel_vld;
    logic [ID_W:0]      w_cand;
    logic               w_own_req;
    logic               w_others;
    logic               w_timeout;
    logic [ID_W-1:0]    w_ptr_nxt;

    // Scan upward from ptr with wrap; the extra bit keeps ptr+k from overflowing.
    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_cand >= N_EXT)
                w_cand = w_cand - N_EXT;
            if (!w_sel_vld && bus.req[w_cand[ID_W-1:0]]) begin
                w_sel     = w_cand[ID_W-1:0];
                w_sel_vld = 1'b1;
            end
        end
    end

    assign w_own_req = bus.req[r_gnt_id];
    assign w_others  = |(bus.req & ~r_gnt);
    assign w_timeout = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_ptr_nxt = (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_vld  <= 1'b0;
            r_gnt_id   <= '0;
            r_preempt  <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.en && w_sel_vld) begin
                        r_gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
                        r_gnt_vld  <= 1'b1;
                        r_gnt_id   <= w_sel;
                        r_hold_cnt <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    // Release outranks timeout, so preempt only flags a still-requesting owner.
                    if (!w_own_req || (w_timeout && w_others)) begin
                        r_gnt     <= '0;
                        r_gnt_vld <= 1'b0;
                        r_ptr     <= w_ptr_nxt;
                        r_preempt <= w_own_req;
                        r_state   <= IDLE;
                    end else if (MAX_HOLD != 0 && r_hold_cnt != HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + HC_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_vld = r_gnt_vld;
    assign bus.gnt_id  = r_gnt_id;
    assign bus.preempt = r_preempt;
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Bench for rr_resource_arbiter: three instances (4/16, 4/0, 3/16) share stimulus;
// each driven cycle pushes the expected post-edge outputs of one chosen instance.
module tb_rr_resource_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_resource_arbiter_if #(.NUM_REQ(4)) ifa ();
    rr_resource_arbiter_if #(.NUM_REQ(4)) ifb ();
    rr_resource_arbiter_if #(.NUM_REQ(3)) ifc ();

    rr_resource_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    rr_resource_arbiter #(.NUM_REQ(4), .MAX_HOLD(0))  dut_b (.clk(clk), .rst(rst), .bus(ifb));
    rr_resource_arbiter #(.NUM_REQ(3), .MAX_HOLD(16)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        string      name;
        int         sel;
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       pre;
    } vec_t;

    typedef struct {
        string      name;
        int         sel;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       pre;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic add(string nm, logic r, logic e, logic [3:0] rq,
                       logic [3:0] g, logic [1:0] id, logic p);
        vec_t v;
        v.name = nm; v.sel = 0; v.rst = r; v.en = e; v.req = rq;
        v.gnt = g; v.id = id; v.pre = p;
        tbl.push_back(v);
    endtask

    task automatic drive(string nm, int sel, logic r, logic e, logic [3:0] rq,
                         logic [3:0] g, logic [1:0] id, logic p);
        exp_t x;
        @(negedge clk);
        rst = r;
        ifa.en = e; ifb.en = e; ifc.en = e;
        ifa.req = rq; ifb.req = rq; ifc.req = rq[2:0];
        x.name = nm; x.sel = sel; x.gnt = g; x.id = id; x.pre = p;
        sb.push_back(x);
    endtask

    // Scoreboard consumer: outputs are sampled 1 time unit after each rising edge.
    always begin : mon
        exp_t       e;
        logic [3:0] ag;
        logic       av;
        logic [1:0] aid;
        logic       ap;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       begin ag = ifa.gnt; av = ifa.gnt_vld; aid = ifa.gnt_id; ap = ifa.preempt; end
                1:       begin ag = ifb.gnt; av = ifb.gnt_vld; aid = ifb.gnt_id; ap = ifb.preempt; end
                default: begin ag = {1'b0, ifc.gnt}; av = ifc.gnt_vld; aid = ifc.gnt_id; ap = ifc.preempt; end
            endcase
            n_chk++;
            if ({ag, av, aid, ap} !== {e.gnt, |e.gnt, e.id, e.pre}) begin
                n_fail++;
                $display("FAIL %s (dut%0d): got gnt=%b vld=%b id=%0d pre=%b, expected gnt=%b vld=%b id=%0d pre=%b",
                         e.name, e.sel, ag, av, aid, ap, e.gnt, |e.gnt, e.id, e.pre);
            end
        end
    end

    initial begin
        rst = 1'b1;
        ifa.en = 1'b0; ifb.en = 1'b0; ifc.en = 1'b0;
        ifa.req = '0;  ifb.req = '0;  ifc.req = '0;

        // rst, en, req -> gnt, id, preempt after the edge
        add("reset",           1, 1, 4'b0000, 4'b0000, 2'd0, 0);
        add("reset_over_req",  1, 1, 4'b1111, 4'b0000, 2'd0, 0);
        add("idle_no_req",     0, 1, 4'b0000, 4'b0000, 2'd0, 0);
        add("single_grant",    0, 1, 4'b0100, 4'b0100, 2'd2, 0);
        add("single_hold",     0, 1, 4'b0100, 4'b0100, 2'd2, 0);
        add("single_release",  0, 1, 4'b0000, 4'b0000, 2'd2, 0);
        add("ptr_after_2",     0, 1, 4'b1001, 4'b1000, 2'd3, 0);
        add("release_3",       0, 1, 4'b0000, 4'b0000, 2'd3, 0);
        add("ptr_wrap_0",      0, 1, 4'b1010, 4'b0010, 2'd1, 0);
        add("hold_1",          0, 1, 4'b1010, 4'b0010, 2'd1, 0);
        add("release_1",       0, 1, 4'b1000, 4'b0000, 2'd1, 0);
        add("ptr_2_pick_3",    0, 1, 4'b1010, 4'b1000, 2'd3, 0);
        add("release_3b",      0, 1, 4'b0010, 4'b0000, 2'd3, 0);
        add("en_low_blocks",   0, 0, 4'b0010, 4'b0000, 2'd3, 0);
        add("en_low_blocks2",  0, 0, 4'b0010, 4'b0000, 2'd3, 0);
        add("en_high_grants",  0, 1, 4'b0010, 4'b0010, 2'd1, 0);
        add("en_drop_keeps",   0, 0, 4'b0010, 4'b0010, 2'd1, 0);
        add("en_drop_keeps2",  0, 0, 4'b0110, 4'b0010, 2'd1, 0);
        add("en_low_release",  0, 0, 4'b0100, 4'b0000, 2'd1, 0);
        add("en_low_idle",     0, 0, 4'b0100, 4'b0000, 2'd1, 0);
        add("en_high_no_req",  0, 1, 4'b0000, 4'b0000, 2'd1, 0);
        foreach (tbl[i])
            drive(tbl[i].name, tbl[i].sel, tbl[i].rst, tbl[i].en, tbl[i].req,
                  tbl[i].gnt, tbl[i].id, tbl[i].pre);

        // Rotation: all requesting, each owner holds 2 cycles then drops for one
        drive("rot_reset", 0, 1, 1, 4'b0000, 4'b0000, 2'd0, 0);
        for (int k = 0; k < 4; k++) begin
            drive("rot_grant", 0, 0, 1, 4'b1111, 4'b0001 << k, 2'(k), 0);
            drive("rot_hold",  0, 0, 1, 4'b1111, 4'b0001 << k, 2'(k), 0);
            drive("rot_gap",   0, 0, 1, 4'b1111 & ~(4'b0001 << k), 4'b0000, 2'(k), 0);
        end
        drive("rot_back_0",  0, 0, 1, 4'b1111, 4'b0001, 2'd0, 0);
        drive("rot_end",     0, 0, 1, 4'b0000, 4'b0000, 2'd0, 0);

        // Preemption of owner 1 after 16 grant cycles, req[3] raised at grant cycle 5
        drive("pre_reset", 0, 1, 1, 4'b0000, 4'b0000, 2'd0, 0);
        drive("pre_grant", 0, 0, 1, 4'b0010, 4'b0010, 2'd1, 0);
        for (int i = 1; i <= 15; i++)
            drive("pre_hold", 0, 0, 1, (i >= 5) ? 4'b1010 : 4'b0010, 4'b0010, 2'd1, 0);
        drive("pre_pulse",   0, 0, 1, 4'b1010, 4'b0000, 2'd1, 1);
        drive("pre_next_3",  0, 0, 1, 4'b1010, 4'b1000, 2'd3, 0);
        drive("pre_hold_3",  0, 0, 1, 4'b1010, 4'b1000, 2'd3, 0);
        drive("pre_rel_3",   0, 0, 1, 4'b0010, 4'b0000, 2'd3, 0);
        drive("pre_regrant", 0, 0, 1, 4'b0010, 4'b0010, 2'd1, 0);
        drive("pre_end",     0, 0, 1, 4'b0000, 4'b0000, 2'd1, 0);

        // Release and timeout in the same cycle: release wins, no pulse
        drive("rw_reset", 0, 1, 1, 4'b0000, 4'b0000, 2'd0, 0);
        drive("rw_grant", 0, 0, 1, 4'b0001, 4'b0001, 2'd0, 0);
        for (int i = 1; i <= 15; i++)
            drive("rw_hold", 0, 0, 1, 4'b0011, 4'b0001, 2'd0, 0);
        drive("rw_release", 0, 0, 1, 4'b0010, 4'b0000, 2'd0, 0);
        drive("rw_next_1",  0, 0, 1, 4'b0010, 4'b0010, 2'd1, 0);
        drive("rw_end",     0, 0, 1, 4'b0000, 4'b0000, 2'd1, 0);

        // Alone for 100 cycles; the saturated counter preempts as soon as a rival appears
        drive("alone_reset", 0, 1, 1, 4'b0000, 4'b0000, 2'd0, 0);
        drive("alone_grant", 0, 0, 1, 4'b0001, 4'b0001, 2'd0, 0);
        for (int i = 0; i < 100; i++)
            drive("alone_hold", 0, 0, 1, 4'b0001, 4'b0001, 2'd0, 0);
        drive("alone_rival_pre", 0, 0, 1, 4'b0101, 4'b0000, 2'd0, 1);
        drive("alone_next_2",    0, 0, 1, 4'b0101, 4'b0100, 2'd2, 0);
        drive("alone_end",       0, 0, 1, 4'b0000, 4'b0000, 2'd2, 0);

        // MAX_HOLD=0: owner 0 keeps the grant despite req[1]
        drive("nopre_reset", 1, 1, 1, 4'b0000, 4'b0000, 2'd0, 0);
        drive("nopre_grant", 1, 0, 1, 4'b0011, 4'b0001, 2'd0, 0);
        for (int i = 0; i < 100; i++)
            drive("nopre_hold", 1, 0, 1, 4'b0011, 4'b0001, 2'd0, 0);
        drive("nopre_release", 1, 0, 1, 4'b0010, 4'b0000, 2'd0, 0);
        drive("nopre_next_1",  1, 0, 1, 4'b0010, 4'b0010, 2'd1, 0);
        drive("nopre_end",     1, 0, 1, 4'b0000, 4'b0000, 2'd1, 0);

        // NUM_REQ=3: mid-grant reset and ptr wrap from 2 to 0
        drive("odd_reset",      2, 1, 1, 4'b0000, 4'b0000, 2'd0, 0);
        drive("odd_grant_2",    2, 0, 1, 4'b0100, 4'b0100, 2'd2, 0);
        drive("odd_hold_2",     2, 0, 1, 4'b0100, 4'b0100, 2'd2, 0);
        drive("odd_mid_reset",  2, 1, 1, 4'b0100, 4'b0000, 2'd0, 0);
        drive("odd_after_rst",  2, 0, 1, 4'b0101, 4'b0001, 2'd0, 0);
        drive("odd_rel_0",      2, 0, 1, 4'b0100, 4'b0000, 2'd0, 0);
        drive("odd_ptr1_pick2", 2, 0, 1, 4'b0101, 4'b0100, 2'd2, 0);
        drive("odd_rel_2",      2, 0, 1, 4'b0001, 4'b0000, 2'd2, 0);
        drive("odd_wrap_0",     2, 0, 1, 4'b0101, 4'b0001, 2'd0, 0);
        drive("odd_end",        2, 0, 1, 4'b0000, 4'b0000, 2'd0, 0);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
